alu_arbiter: RTL and testbench

Two-port arbiter and sequencer that shares one combinational 32-bit ALU between two requesters, such as a main issue port and a secondary/debug port. It accepts an operation from one requester per transaction with round-robin fairness and drives the registered operands and select onto the shared ALU. It captures the result and zero flag one cycle later, then returns them to the requester that issued the operation, using a valid/ready response handshake.

---
 rtl/alu_arbiter.sv | 131 +++++++++++++
 tb/tb_alu_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for one shared combinational ALU.
// One operation in flight at a time: latch operands, capture result, hand it back.
module alu_arbiter #(
    parameter int W  = 32,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [W-1:0]  req0_a,
    input  logic [W-1:0]  req0_b,
    input  logic [1:0]    req0_op,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [W-1:0]  req1_a,
    input  logic [W-1:0]  req1_b,
    input  logic [1:0]    req1_op,
    output logic          rsp0_valid,
    input  logic          rsp0_ready,
    output logic          rsp1_valid,
    input  logic          rsp1_ready,
    output logic [W-1:0]  rsp_data,
    output logic          rsp_zf,
    output logic [W-1:0]  alu_a,
    output logic [W-1:0]  alu_b,
    output logic [1:0]    alu_s,
    input  logic [W-1:0]  alu_out,
    input  logic          alu_zf,
    output logic          busy,
    output logic [CW-1:0] ops_done
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t        state_q, state_d;
    logic          prio_q, prio_d;
    logic          owner_q, owner_d;
    logic [W-1:0]  a_q, a_d, b_q, b_d;
    logic [1:0]    s_q, s_d;
    logic [W-1:0]  data_q, data_d;
    logic          zf_q, zf_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q;

    logic gnt1, hs0, hs1, rsp_hs;

    // Grant and handshake decode; ready is masked during reset.
    always_comb begin
        gnt1       = req1_valid && (!req0_valid || prio_q);
        req0_ready = !rst && (state_q == IDLE) && req0_valid && !gnt1;
        req1_ready = !rst && (state_q == IDLE) && gnt1;
        hs0        = req0_valid && req0_ready;
        hs1        = req1_valid && req1_ready;
        rsp0_valid = (state_q == RESP) && !owner_q;
        rsp1_valid = (state_q == RESP) && owner_q;
        rsp_hs     = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);
    end

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        owner_d = owner_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        data_d  = data_q;
        zf_d    = zf_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (hs0 || hs1) begin
                    a_d     = hs1 ? req1_a  : req0_a;
                    b_d     = hs1 ? req1_b  : req0_b;
                    s_d     = hs1 ? req1_op : req0_op;
                    owner_d = hs1;
                    // Priority passes to the requester that was not just served.
                    prio_d  = !hs1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                data_d  = alu_out;
                zf_d    = alu_zf;
                state_d = RESP;
            end
            RESP: begin
                if (rsp_hs) begin
                    cnt_d   = cnt_q + CW'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            owner_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= 2'b00;
            data_q  <= '0;
            zf_q    <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            owner_q <= owner_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            data_q  <= data_d;
            zf_q    <= zf_d;
            cnt_q   <= cnt_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    assign alu_a    = a_q;
    assign alu_b    = b_q;
    assign alu_s    = s_q;
    assign rsp_data = data_q;
    assign rsp_zf   = zf_q;
    assign busy     = busy_q;
    assign ops_done = cnt_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: transaction-level model checked every cycle,
// plus literal expectations on results, latency, grant order and the counter.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [1:0]  req0_op = '0, req1_op = '0;
    logic        rsp0_valid, rsp1_valid;
    logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
    logic [31:0] rsp_data, alu_a, alu_b, alu_out;
    logic        rsp_zf, alu_zf, busy;
    logic [1:0]  alu_s;
    logic [3:0]  ops_done;

    int nchk = 0;
    int nfail = 0;
    int grants[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] s);
        case (s)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a + b;
            default: return (a < b) ? 32'd1 : 32'd0;
        endcase
    endfunction

    assign alu_out = alu_fn(alu_a, alu_b, alu_s);
    assign alu_zf  = (alu_out == 32'd0);

    alu_arbiter #(.W(32), .CW(4)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_data(rsp_data), .rsp_zf(rsp_zf),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s),
        .alu_out(alu_out), .alu_zf(alu_zf),
        .busy(busy), .ops_done(ops_done)
    );

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Transaction model: one pending op, result known from its operands at accept time.
    logic        m_pend = 0, m_resp = 0, m_owner = 0, m_prio = 0, m_zf = 0;
    logic [31:0] m_a = 0, m_b = 0, m_data = 0;
    logic [1:0]  m_s = 0;
    int          m_cnt = 0;

    always @(posedge clk) begin
        logic who;
        if (rst) begin
            m_pend = 0; m_resp = 0; m_owner = 0; m_prio = 0;
            m_a = 0; m_b = 0; m_s = 0; m_data = 0; m_zf = 0; m_cnt = 0;
        end else if (m_pend) begin
            if (!m_resp) begin
                m_resp = 1;
                m_data = alu_fn(m_a, m_b, m_s);
                m_zf   = (m_data == 0);
            end else if (m_owner ? rsp1_ready : rsp0_ready) begin
                m_pend = 0; m_resp = 0;
                m_cnt  = (m_cnt + 1) % 16;
            end
        end else if (req0_valid || req1_valid) begin
            who     = (req0_valid && req1_valid) ? m_prio : req1_valid;
            m_a     = who ? req1_a : req0_a;
            m_b     = who ? req1_b : req0_b;
            m_s     = who ? req1_op : req0_op;
            m_owner = who;
            m_prio  = !who;
            m_pend  = 1;
        end
    end

    always @(negedge clk) begin
        logic e_r0, e_r1;
        e_r0 = !rst && !m_pend && req0_valid && (!req1_valid || !m_prio);
        e_r1 = !rst && !m_pend && req1_valid && (!req0_valid || m_prio);
        chk("m_req0_ready", 32'(req0_ready), 32'(e_r0));
        chk("m_req1_ready", 32'(req1_ready), 32'(e_r1));
        chk("m_rsp0_valid", 32'(rsp0_valid), 32'(m_resp && !m_owner));
        chk("m_rsp1_valid", 32'(rsp1_valid), 32'(m_resp && m_owner));
        chk("m_rsp_data", rsp_data, m_data);
        chk("m_rsp_zf", 32'(rsp_zf), 32'(m_zf));
        chk("m_alu_a", alu_a, m_a);
        chk("m_alu_b", alu_b, m_b);
        chk("m_alu_s", 32'(alu_s), 32'(m_s));
        chk("m_busy", 32'(busy), 32'(m_pend));
        chk("m_ops_done", 32'(ops_done), m_cnt);
        if (!rst && req0_valid && req0_ready) grants.push_back(0);
        if (!rst && req1_valid && req1_ready) grants.push_back(1);
    end

    task automatic do_op(input int p, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] op, input logic [31:0] exp_d, input logic exp_z,
                         input int hold, output int rwait, output int lat);
        bit done;
        if (p == 0) begin req0_a = a; req0_b = b; req0_op = op; req0_valid = 1; end
        else        begin req1_a = a; req1_b = b; req1_op = op; req1_valid = 1; end
        rwait = 0; done = 0;
        while (!done) begin
            @(negedge clk);
            if ((p == 0) ? req0_ready : req1_ready) done = 1;
            else begin
                rwait++;
                if (rwait > 40) begin chk("ready_timeout", 32'(rwait), 0); done = 1; end
            end
        end
        @(posedge clk); #1;
        if (p == 0) req0_valid = 0; else req1_valid = 0;
        lat = 0; done = 0;
        while (!done) begin
            @(negedge clk);
            lat++;
            if ((p == 0) ? rsp0_valid : rsp1_valid) done = 1;
            else if (lat > 40) begin chk("rsp_timeout", 32'(lat), 0); done = 1; end
        end
        chk("rsp_data", rsp_data, exp_d);
        chk("rsp_zf", 32'(rsp_zf), 32'(exp_z));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_valid", 32'((p == 0) ? rsp0_valid : rsp1_valid), 1);
            chk("hold_data", rsp_data, exp_d);
            chk("hold_zf", 32'(rsp_zf), 32'(exp_z));
            chk("hold_no_ready", 32'(req0_ready | req1_ready), 0);
            chk("hold_busy", 32'(busy), 1);
        end
        if (p == 0) rsp0_ready = 1; else rsp1_ready = 1;
        @(posedge clk); #1;
        if (p == 0) rsp0_ready = 0; else rsp1_ready = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int rw, lt;
        // Reset with a request already pending: ready must stay low.
        req0_valid = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_ready0", 32'(req0_ready), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_ops", 32'(ops_done), 0);
        chk("reset_alu_a", alu_a, 0);
        @(posedge clk); #1;
        rst = 0; req0_valid = 0;
        @(posedge clk); #1;

        do_op(0, 32'd5, 32'd7, 2'b10, 32'd12, 1'b0, 0, rw, lt);
        chk("single_ready_wait", 32'(rw), 0);
        chk("single_latency", 32'(lt), 2);
        @(negedge clk);
        chk("single_ops_done", 32'(ops_done), 1);
        @(posedge clk); #1;

        do_op(1, 32'hF0F0_0000, 32'h0F0F_FFFF, 2'b00, 32'd0, 1'b1, 0, rw, lt);
        do_op(1, 32'h1, 32'h2, 2'b01, 32'd3, 1'b0, 0, rw, lt);
        do_op(1, 32'd3, 32'd9, 2'b11, 32'd1, 1'b0, 0, rw, lt);
        do_op(1, 32'd9, 32'd3, 2'b11, 32'd0, 1'b1, 0, rw, lt);
        do_op(1, 32'hFFFF_FFFF, 32'd1, 2'b11, 32'd0, 1'b1, 0, rw, lt);
        @(negedge clk);
        chk("opcode_ops_done", 32'(ops_done), 6);
        @(posedge clk); #1;

        // Contention: both ports back-to-back, two ops each.
        grants.delete();
        fork
            begin
                int r, l;
                do_op(0, 32'd10, 32'd1, 2'b10, 32'd11, 1'b0, 0, r, l);
                do_op(0, 32'd20, 32'd2, 2'b10, 32'd22, 1'b0, 0, r, l);
            end
            begin
                int r, l;
                do_op(1, 32'hFF, 32'h0F, 2'b00, 32'h0F, 1'b0, 0, r, l);
                do_op(1, 32'h30, 32'h03, 2'b01, 32'h33, 1'b0, 0, r, l);
            end
        join
        chk("contend_count", grants.size(), 4);
        if (grants.size() == 4) begin
            chk("contend_g0", grants[0], 0);
            chk("contend_g1", grants[1], 1);
            chk("contend_g2", grants[2], 0);
            chk("contend_g3", grants[3], 1);
        end

        // Backpressure on req1 while req0 waits.
        fork
            begin
                int r, l;
                do_op(1, 32'd100, 32'd23, 2'b10, 32'd123, 1'b0, 5, r, l);
            end
            begin
                int r, l;
                repeat (2) @(posedge clk);
                #1;
                do_op(0, 32'h8, 32'h4, 2'b01, 32'hC, 1'b0, 0, r, l);
            end
        join
        @(negedge clk);
        chk("bp_ops_done", 32'(ops_done), 12);

        // Reset during EXEC aborts the op.
        @(posedge clk); #1;
        req0_a = 32'd1; req0_b = 32'd2; req0_op = 2'b10; req0_valid = 1;
        @(negedge clk);
        chk("abort_grant", 32'(req0_ready), 1);
        @(posedge clk); #1;
        req0_valid = 0; rst = 1;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_rsp0", 32'(rsp0_valid), 0);
        chk("abort_data", rsp_data, 0);
        chk("abort_alu_a", alu_a, 0);
        chk("abort_alu_s", 32'(alu_s), 0);
        chk("abort_ops", 32'(ops_done), 0);
        repeat (5) begin
            @(negedge clk);
            chk("abort_no_rsp", 32'(rsp0_valid | rsp1_valid), 0);
        end
        @(posedge clk); #1;

        // Counter wrap with a 4-bit counter.
        for (int i = 0; i < 17; i++)
            do_op(0, i, 32'd1, 2'b10, i + 1, 1'b0, 0, rw, lt);
        @(negedge clk);
        chk("wrap_ops_done", 32'(ops_done), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
